// File: rtl/pe_mc_pkg.sv
// Shared types and arithmetic helpers for the multi-channel streaming PE.
// The helpers work on 64-bit containers, so ACC_WIDTH must be 64 or less.
package pe_mc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    PSUM,
    OUT
  } state_t;

  localparam int unsigned FN_W = 64;

  // Sign-extends the low w bits of v to the full container width.
  function automatic logic [FN_W-1:0] sign_ext(input logic [FN_W-1:0] v, input int unsigned w);
    logic [FN_W-1:0] upper;
    logic [FN_W-1:0] msb_sel;
    upper   = ~(FN_W'(0)) << w;
    msb_sel = v >> (w - 1);
    return msb_sel[0] ? (v | upper) : (v & ~upper);
  endfunction

  // Adds two sign-extended w-bit values and clamps to the signed w-bit range.
  function automatic logic [FN_W-1:0] sat_add(input logic [FN_W-1:0] a, input logic [FN_W-1:0] b,
                                              input int unsigned w);
    logic signed [FN_W:0] s;
    logic signed [FN_W:0] hi;
    logic signed [FN_W:0] lo;
    s  = $signed({a[FN_W-1], a}) + $signed({b[FN_W-1], b});
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    if (s > hi) return hi[FN_W-1:0];
    if (s < lo) return lo[FN_W-1:0];
    return s[FN_W-1:0];
  endfunction

  function automatic logic [2:0] clamp_k(input logic [2:0] ks, input logic [2:0] kmax);
    if (ks == 3'd0) return 3'd1;
    if (ks > kmax) return kmax;
    return ks;
  endfunction

endpackage

// File: rtl/pe_mc_mult_pipe.sv
// NUM_CH signed multipliers sharing one ifmap operand, followed by MULT_LAT
// register stages with a parallel valid shift register and synchronous flush.
module pe_mc_mult_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int MULT_LAT   = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic signed [DATA_WIDTH-1:0]   ifmap_data,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   fltr_data,
  output logic                           out_valid,
  output logic [NUM_CH*2*DATA_WIDTH-1:0] prod_data
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [NUM_CH*PW-1:0] prod_in;
  logic [NUM_CH*PW-1:0] stage_q [MULT_LAT];
  logic [MULT_LAT-1:0]  valid_q;

  always_comb begin
    prod_in = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      prod_in[c*PW +: PW] = PW'($signed(ifmap_data)) * PW'($signed(fltr_data[c*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  // Data stages run freely; only the valid bits decide what reaches the accumulator.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < MULT_LAT; i++) stage_q[i] <= '0;
    end else begin
      valid_q[0] <= flush ? 1'b0 : in_valid;
      stage_q[0] <= prod_in;
      for (int i = 1; i < MULT_LAT; i++) begin
        valid_q[i] <= flush ? 1'b0 : valid_q[i-1];
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[MULT_LAT-1];
  assign prod_data = stage_q[MULT_LAT-1];

endmodule

// File: rtl/pe_mc_stream.sv
// Multi-channel streaming convolution PE: K*K taps per window, psum add, opsum out.
// Define PE_MC_SAT_EN to saturate accumulation and psum add instead of wrapping.
module pe_mc_stream
  import pe_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int NUM_CH     = 4,
  parameter int MAX_KERNEL = 5,
  parameter int MULT_LAT   = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  input  logic [2:0]                    kernel_size,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_WIDTH-1:0]  ifmap_data,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  fltr_data,
  input  logic                          ipsum_valid,
  output logic                          ipsum_ready,
  input  logic                          ipsum_bypass,
  input  logic [NUM_CH*ACC_WIDTH-1:0]   ipsum_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH*ACC_WIDTH-1:0]   opsum_data,
  output logic                          busy
);

  localparam int PW     = 2 * DATA_WIDTH;
  localparam int CNT_W  = $clog2(MAX_KERNEL * MAX_KERNEL + 1);
  localparam int DCNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  state_t               state, state_n;
  logic [2:0]           k_q, k_new;
  logic [CNT_W-1:0]     count, kk;
  logic [DCNT_W-1:0]    drain_cnt;
  logic                 tap_fire, psum_take, out_fire;
  logic                 pipe_valid;
  logic [NUM_CH*PW-1:0] pipe_prod;

  assign k_new     = clamp_k(kernel_size, 3'(MAX_KERNEL));
  assign kk        = CNT_W'(k_q) * CNT_W'(k_q);
  assign in_ready  = en && (state == IDLE || state == ACCUM);
  assign tap_fire  = in_valid && in_ready;
  assign psum_take = en && (state == PSUM) && (ipsum_bypass || ipsum_valid);
  assign ipsum_ready = en && (state == PSUM) && !ipsum_bypass && ipsum_valid;
  assign out_valid = (state == OUT);
  assign out_fire  = out_valid && out_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (tap_fire) state_n = (k_new == 3'd1) ? DRAIN : ACCUM;
        ACCUM:   if (tap_fire && (count + 1'b1) == kk) state_n = DRAIN;
        DRAIN:   if (drain_cnt == DCNT_W'(MULT_LAT - 1)) state_n = PSUM;
        PSUM:    if (psum_take) state_n = OUT;
        OUT:     if (out_fire) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // K is captured with the first tap so a kernel_size change mid-window has no effect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k_q       <= 3'd1;
      count     <= '0;
      drain_cnt <= '0;
    end else if (!en) begin
      count     <= '0;
      drain_cnt <= '0;
    end else begin
      if (tap_fire) begin
        if (state == IDLE) begin
          k_q   <= k_new;
          count <= CNT_W'(1);
        end else begin
          count <= count + 1'b1;
        end
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  pe_mc_mult_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CH     (NUM_CH),
    .MULT_LAT   (MULT_LAT)
  ) u_mult (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (!en),
    .in_valid   (tap_fire),
    .ifmap_data (ifmap_data),
    .fltr_data  (fltr_data),
    .out_valid  (pipe_valid),
    .prod_data  (pipe_prod)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] psum_add;
    logic signed [ACC_WIDTH-1:0] step1;
    logic signed [ACC_WIDTH-1:0] step2;

    assign prod_ext = pipe_valid ? ACC_WIDTH'($signed(pipe_prod[c*PW +: PW])) : '0;
    assign psum_add = (psum_take && !ipsum_bypass) ? ipsum_data[c*ACC_WIDTH +: ACC_WIDTH] : '0;

`ifdef PE_MC_SAT_EN
    assign step1 = ACC_WIDTH'(sat_add(sign_ext(64'($unsigned(acc_q)), ACC_WIDTH),
                                      sign_ext(64'($unsigned(prod_ext)), ACC_WIDTH), ACC_WIDTH));
    assign step2 = ACC_WIDTH'(sat_add(sign_ext(64'($unsigned(step1)), ACC_WIDTH),
                                      sign_ext(64'($unsigned(psum_add)), ACC_WIDTH), ACC_WIDTH));
`else
    assign step1 = acc_q + prod_ext;
    assign step2 = step1 + psum_add;
`endif

    // Products land whenever the pipeline says so, independent of FSM state.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                acc_q <= '0;
      else if (!en || out_fire) acc_q <= '0;
      else                      acc_q <= step2;
    end

    assign opsum_data[c*ACC_WIDTH +: ACC_WIDTH] = acc_q;
  end

endmodule

// File: doc/pe_mc_stream.md
Name: pe_mc_stream

Overview:
- Multi-channel, streaming successor of the single-lane convolution processing element.
- One ifmap sample per tap is broadcast to NUM_CH filter lanes. Each lane accumulates K*K products for one window, adds an incoming partial sum, and emits one opsum word per lane.
- Valid/ready handshakes are used on all three streams.
- Sits between the ifmap/filter distribution network and the psum chain of the PE array.

Parameters:
- DATA_WIDTH, 16: signed ifmap/filter element width.
- ACC_WIDTH, 40: signed accumulator/psum width per lane; must be >= 2*DATA_WIDTH.
- NUM_CH, 4: number of parallel filter/output channels.
- MAX_KERNEL, 5: largest supported kernel side K.
- MULT_LAT, 2: multiplier pipeline stages; must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  0 = synchronous flush to IDLE.
- kernel_size  in  3  K, latched when the first tap of a window is accepted.
- in_valid  in  1  tap valid.
- in_ready  out  1  tap accepted when in_valid & in_ready.
- ifmap_data  in  DATA_WIDTH  signed sample, broadcast to all lanes.
- fltr_data  in  NUM_CH*DATA_WIDTH  signed weights; lane c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- ipsum_valid  in  1  incoming psum valid.
- ipsum_ready  out  1  incoming psum consumed.
- ipsum_bypass  in  1  1 = add zero and ignore ipsum_valid.
- ipsum_data  in  NUM_CH*ACC_WIDTH  incoming partial sums.
- out_valid  out  1  opsum valid.
- out_ready  in  1  opsum consumed when out_valid & out_ready.
- opsum_data  out  NUM_CH*ACC_WIDTH  result per lane.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0 except in_ready=1. State IDLE, accumulators, multiplier pipeline and tap counter all cleared. Reset applies mid-window and discards the window.
- en=0 at a clock edge: next state IDLE; accumulators, pipeline valids, counter and out_valid cleared next cycle; in_ready=0 while en=0.
- Kernel size: latched K = clamp(kernel_size, 1, MAX_KERNEL); 0 is treated as 1.
- FSM states: IDLE, ACCUM, DRAIN, PSUM, OUT.
- IDLE: in_ready=1. The first accepted tap latches K and sets count=1. Go to DRAIN if K*K==1, else ACCUM.
- ACCUM: in_ready=1. Each accepted tap increments count. Accepting tap number K*K moves to DRAIN. in_valid gaps are allowed without limit.
- DRAIN: in_ready=0. Stays MULT_LAT cycles until the last product has entered the accumulator, then goes to PSUM.
- PSUM: if ipsum_bypass, or ipsum_valid is high, then acc += ipsum (0 when bypassed), ipsum_ready pulses for that cycle, and state goes to OUT. Otherwise wait.
- OUT: out_valid=1 and opsum_data is held stable until out_ready. On the handshake, accumulators clear and state goes to IDLE. in_ready=0 throughout OUT.
- Latency: with bypass and no stalls, out_valid rises MULT_LAT+1 cycles after the edge that accepts the last tap.
- Throughput: K*K + MULT_LAT + 2 cycles per window at best.
- Arithmetic: products are signed 2*DATA_WIDTH, sign-extended to ACC_WIDTH. Accumulation and the psum add wrap modulo 2^ACC_WIDTH.
- Accumulation is gated only by the multiplier valid pipeline, never by FSM state, so no product is lost or double-counted.
- ipsum_ready is never asserted outside PSUM. out_valid is never deasserted without a handshake except by en=0 or reset.

Optional Feature:
- Macro: PE_MC_SAT_EN.
- Defined: every accumulate and the psum add saturate to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
- Not defined: two's-complement wrap-around; no saturation logic is synthesised.

Decomposition:
- Package pe_mc_pkg: FSM state enum; ACC_WIDTH-parametrised helper functions for sign-extend, saturating add, and K clamp.
- Sub-module pe_mc_mult_pipe: NUM_CH signed multipliers, MULT_LAT register stages plus a parallel valid shift register, synchronous flush input.

Test Plan:
- NUM_CH=2, K=3, ifmap=2 every tap, fltr ch0=3, ch1=-1, ipsum={100,5}, bypass=0 -> opsum={154,-13}. out_valid rises MULT_LAT+1 cycles after the 9th tap; ipsum_ready is a single pulse.
- Same window with in_valid toggling every other cycle and out_ready held low 5 cycles -> same values; opsum_data stable while stalled; in_ready=0 during DRAIN/PSUM/OUT.
- K=1, ifmap=-4, fltr ch0=7, bypass=1 -> opsum ch0=-28; ipsum_ready stays 0.
- kernel_size=0 -> window of 1 tap; kernel_size=7 with MAX_KERNEL=5 -> window of exactly 25 taps.
- en dropped after 4 of 9 taps, then a fresh window of all-1 data with K=3 -> opsum=9 per lane, no residue from the aborted window. Repeat with rstn pulsed mid-window instead: same result.
- ipsum ch0 = 2^39-1, one tap 1*1 -> without PE_MC_SAT_EN opsum = -2^39; with it, opsum = 2^39-1.
